fifo_umbral: RTL and testbench



---
 rtl/fifo_umbral.sv | 111 +++++++++++
 tb/tb_fifo_umbral.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_umbral.sv
// rtl/fifo_umbral.sv - programmable-threshold synchronous FIFO feeding the flow-control FSM
// Optional saturating rejected-request counter (err_cnt) enabled by defining FIFO_ERR_CNT_EN.
module fifo_umbral #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [ADDR_WIDTH:0]   umbral_alto,
    input  logic [ADDR_WIDTH:0]   umbral_bajo,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
`ifdef FIFO_ERR_CNT_EN
    ,
    output logic [3:0]            err_cnt
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   alto_q;
    logic [ADDR_WIDTH:0]   bajo_q;

    logic rd_ok;
    logic wr_ok;
    logic overflow;
    logic underflow;

    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= alto_q);
    assign almost_empty = (count <= bajo_q);

    // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
    assign rd_ok     = rd_en && !empty;
    assign wr_ok     = wr_en && (!full || rd_ok);
    assign overflow  = wr_en && !wr_ok;
    assign underflow = rd_en && empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            error     <= 1'b0;
            alto_q    <= DEPTH_CNT;
            bajo_q    <= '0;
        end else if (init) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid_out <= 1'b0;
            error     <= 1'b0;
            alto_q    <= umbral_alto;
            bajo_q    <= umbral_bajo;
        end else begin
            valid_out <= rd_ok;
            if (rd_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                count <= count + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count <= count - 1'b1;
            end
            if (overflow || underflow) begin
                error <= 1'b1;
            end
        end
    end

    // Storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (!init && wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

`ifdef FIFO_ERR_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt <= '0;
        end else if (init) begin
            err_cnt <= '0;
        end else if ((overflow || underflow) && (err_cnt != 4'hF)) begin
            err_cnt <= err_cnt + 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_umbral.sv
// tb/tb_fifo_umbral.sv - directed self-checking bench for fifo_umbral
module tb_fifo_umbral;

    logic       clk;
    logic       reset;
    logic       init;
    logic [3:0] umbral_alto;
    logic [3:0] umbral_bajo;
    logic       wr_en;
    logic [5:0] data_in;
    logic       rd_en;
    logic [5:0] data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       error;
`ifdef FIFO_ERR_CNT_EN
    logic [3:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fifo_umbral #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .umbral_alto  (umbral_alto),
        .umbral_bajo  (umbral_bajo),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error)
`ifdef FIFO_ERR_CNT_EN
        ,
        .err_cnt      (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init();
        init = 1'b1;
        tick();
        init = 1'b0;
    endtask

    task automatic write_word(input logic [5:0] d);
        wr_en   = 1'b1;
        rd_en   = 1'b0;
        data_in = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic read_word();
        rd_en = 1'b1;
        wr_en = 1'b0;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0; init = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        data_in = '0; umbral_alto = 4'd6; umbral_bajo = 4'd2;
        tick();
        tick();
        reset = 1'b1;
        tick();

        // reset state
        chk("rst_empty", empty, 1);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_error", error, 0);
        chk("rst_valid", valid_out, 0);

        // init load of thresholds 6/2 then partial fill
        do_init();
        for (int k = 1; k <= 6; k++) begin
            write_word(6'(k));
            chk("init_aempty", almost_empty, (k <= 2) ? 1 : 0);
            chk("init_afull", almost_full, (k >= 6) ? 1 : 0);
            chk("init_full", full, 0);
        end

        // fill and drain
        do_init();
        for (int i = 0; i < 8; i++) write_word(6'(8'h10 + i));
        chk("fill_full", full, 1);
        chk("fill_afull", almost_full, 1);
        for (int i = 0; i < 8; i++) begin
            read_word();
            chk("drain_valid", valid_out, 1);
            chk("drain_data", data_out, 8'h10 + i);
        end
        chk("drain_empty", empty, 1);
        chk("drain_error", error, 0);
        tick();
        chk("drain_valid_low", valid_out, 0);

        // overflow then underflow
        for (int i = 0; i < 8; i++) write_word(6'(8'h10 + i));
        write_word(6'h3F);
        chk("ovf_error", error, 1);
        chk("ovf_full", full, 1);
        read_word();
        chk("ovf_first_data", data_out, 8'h10);
        for (int i = 1; i < 8; i++) read_word();
        chk("ovf_last_data", data_out, 8'h17);
        chk("ovf_empty", empty, 1);
        read_word();
        chk("udf_valid", valid_out, 0);
        chk("udf_error", error, 1);
        do_init();
        chk("init_clr_error", error, 0);
        chk("init_clr_empty", empty, 1);

        // simultaneous access when full
        for (int i = 0; i < 8; i++) write_word(6'(8'h30 + i));
        wr_en = 1'b1; rd_en = 1'b1; data_in = 6'h2A;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("sim_full_data", data_out, 8'h30);
        chk("sim_full_valid", valid_out, 1);
        chk("sim_full_full", full, 1);
        chk("sim_full_error", error, 0);
        for (int i = 1; i < 8; i++) read_word();
        chk("sim_pre_data", data_out, 8'h37);
        read_word();
        chk("sim_2a_data", data_out, 8'h2A);
        chk("sim_2a_empty", empty, 1);

        // simultaneous access when empty: no fall-through
        wr_en = 1'b1; rd_en = 1'b1; data_in = 6'h3C;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("sim_empty_valid", valid_out, 0);
        chk("sim_empty_empty", empty, 0);
        chk("sim_empty_error", error, 1);
        read_word();
        chk("sim_empty_data", data_out, 8'h3C);
        chk("sim_empty_after", empty, 1);

        // threshold edge cases: alto=0, bajo=DEPTH
        umbral_alto = 4'd0; umbral_bajo = 4'd8;
        do_init();
        chk("edge_afull_empty", almost_full, 1);
        chk("edge_aempty_empty", almost_empty, 1);
        for (int i = 0; i < 8; i++) write_word(6'(i));
        chk("edge_afull_full", almost_full, 1);
        chk("edge_aempty_full", almost_empty, 1);
        chk("edge_full", full, 1);
        umbral_alto = 4'd6; umbral_bajo = 4'd2;

        // async reset mid-cycle with 5 words stored
        do_init();
        for (int i = 0; i < 5; i++) write_word(6'(8'h20 + i));
        chk("ar_pre_empty", empty, 0);
        #3;
        reset = 1'b0;
        #1;
        chk("ar_empty", empty, 1);
        chk("ar_aempty", almost_empty, 1);
        chk("ar_afull", almost_full, 0);
        chk("ar_valid", valid_out, 0);
        tick();
        reset = 1'b1;
        tick();
        write_word(6'h07);
        read_word();
        chk("ar_post_data", data_out, 8'h07);
        chk("ar_post_empty", empty, 1);

`ifdef FIFO_ERR_CNT_EN
        do_init();
        chk("ec_zero", err_cnt, 0);
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("ec_three", err_cnt, 3);
        for (int i = 0; i < 17; i++) tick();
        rd_en = 1'b0;
        chk("ec_sat", err_cnt, 15);
        do_init();
        chk("ec_clear", err_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
